// File: rtl/mult_seq_n_if.sv
// Operand/result bundle for the sequential add-shift multiplier.
// The controls are active-low. The results come straight from the multiplier's registers.
interface mult_seq_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ClearA_LoadB;
  logic             Run;
  logic [WIDTH-1:0] S;
  logic             X;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Busy;
  logic             Done;

  modport master (
    output ClearA_LoadB, Run, S,
    input  X, Aval, Bval, Busy, Done
  );

  modport slave (
    input  ClearA_LoadB, Run, S,
    output X, Aval, Bval, Busy, Done
  );
endinterface

// File: rtl/mult_seq_n.sv
// Parametrised sequential add-shift multiplier. The product is left in A:B, with the sign/carry in X.
// Signed mode subtracts the multiplicand on the final step. B keeps the low half, so runs can be chained.
module mult_seq_n #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  mult_seq_n_if.slave bus
);
  localparam int unsigned       CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt, b, b_nxt, m, m_nxt;
  logic             x, x_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy, busy_nxt, done, done_nxt;
  logic [WIDTH:0]   ext_a, ext_m, sum;

  // State and datapath registers; reset wins over everything
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      m     <= '0;
      x     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      m     <= m_nxt;
      x     <= x_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Partial-product adder at WIDTH+1 bits. In signed mode the final step subtracts the multiplicand.
  always_comb begin
    ext_a = SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
    ext_m = SIGNED ? {m[WIDTH-1], m} : {1'b0, m};
    sum   = (SIGNED && (cnt == LAST)) ? (ext_a - ext_m) : (ext_a + ext_m);
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    m_nxt     = m;
    x_nxt     = x;
    cnt_nxt   = cnt;

    unique case (state)
      IDLE: begin
        if (!bus.Run) begin
          m_nxt     = bus.S;
          a_nxt     = '0;
          x_nxt     = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ADD;
        end else if (!bus.ClearA_LoadB) begin
          b_nxt = bus.S;
          a_nxt = '0;
          x_nxt = 1'b0;
        end
      end
      ADD: begin
        if (b[0]) {x_nxt, a_nxt} = sum;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        x_nxt     = SIGNED ? x : 1'b0;
        a_nxt     = {x, a[WIDTH-1:1]};
        b_nxt     = {a[0], b[WIDTH-1:1]};
        cnt_nxt   = cnt + CW'(1);
        state_nxt = (cnt == LAST) ? DONE : ADD;
      end
      DONE: begin
        // Run must be seen high before the block returns to IDLE, so a held Run cannot re-trigger
        if (bus.Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == ADD) || (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.X    = x;
  assign bus.Aval = a;
  assign bus.Bval = b;
  assign bus.Busy = busy;
  assign bus.Done = done;
endmodule

// File: tb/tb_mult_seq_n.sv
// Directed bench for mult_seq_n covering three instances: 8-bit signed, 8-bit unsigned and 16-bit signed.
// It runs a vector table first and then hand-written sequences for hold, priority, interference and reset.
module tb_mult_seq_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_n_if #(.WIDTH(8))  if8s ();
  mult_seq_n_if #(.WIDTH(8))  if8u ();
  mult_seq_n_if #(.WIDTH(16)) if16s ();

  mult_seq_n #(.WIDTH(8),  .SIGNED(1'b1)) dut8s  (.Clk(clk), .Reset(rst), .bus(if8s));
  mult_seq_n #(.WIDTH(8),  .SIGNED(1'b0)) dut8u  (.Clk(clk), .Reset(rst), .bus(if8u));
  mult_seq_n #(.WIDTH(16), .SIGNED(1'b1)) dut16s (.Clk(clk), .Reset(rst), .bus(if16s));

  int n_cmp = 0;
  int n_bad = 0;

  // d: 0 = 8-bit signed, 1 = 8-bit unsigned, 2 = 16-bit signed; load=0 chains from the current B
  typedef struct {
    int          d;
    logic        load;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ex;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic clr, input logic run, input logic [31:0] s);
    case (d)
      0: begin if8s.ClearA_LoadB = clr;  if8s.Run = run;  if8s.S = s[7:0];   end
      1: begin if8u.ClearA_LoadB = clr;  if8u.Run = run;  if8u.S = s[7:0];   end
      default: begin if16s.ClearA_LoadB = clr; if16s.Run = run; if16s.S = s[15:0]; end
    endcase
  endtask

  task automatic sample(input int d, output logic x, output logic [31:0] a, output logic [31:0] b,
                        output logic busy, output logic done);
    case (d)
      0: begin x = if8s.X; a = 32'(if8s.Aval); b = 32'(if8s.Bval); busy = if8s.Busy; done = if8s.Done; end
      1: begin x = if8u.X; a = 32'(if8u.Aval); b = 32'(if8u.Bval); busy = if8u.Busy; done = if8u.Done; end
      default: begin
        x = if16s.X; a = 32'(if16s.Aval); b = 32'(if16s.Bval); busy = if16s.Busy; done = if16s.Done;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input int d, input logic [31:0] ea,
                              input logic [31:0] eb, input logic ex);
    logic x, busy, done;
    logic [31:0] a, b;
    sample(d, x, a, b, busy, done);
    check({tag, " A"},    a, ea);
    check({tag, " B"},    b, eb);
    check({tag, " X"},    32'(x), 32'(ex));
    check({tag, " Done"}, 32'(done), 32'd1);
    check({tag, " Busy"}, 32'(busy), 32'd0);
  endtask

  // One cycle with Run high so a DONE instance returns to IDLE
  task automatic release_run(input string tag, input int d);
    logic x, busy, done;
    logic [31:0] a, b;
    drive(d, 1'b1, 1'b1, 32'd0);
    tick();
    sample(d, x, a, b, busy, done);
    check({tag, " release Done"}, 32'(done), 32'd0);
  endtask

  task automatic load_b(input string tag, input int d, input logic [31:0] bv);
    logic x, busy, done;
    logic [31:0] a, b;
    drive(d, 1'b0, 1'b1, bv);
    tick();
    sample(d, x, a, b, busy, done);
    check({tag, " load B"}, b, bv);
    check({tag, " load A"}, a, 32'd0);
    drive(d, 1'b1, 1'b1, bv);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int w;
    logic x, busy, done;
    logic [31:0] a, b;
    w = (v.d == 2) ? 16 : 8;
    release_run(tag, v.d);
    if (v.load) load_b(tag, v.d, v.b);
    drive(v.d, 1'b1, 1'b0, v.s);
    tick();
    repeat (2 * w - 1) tick();
    sample(v.d, x, a, b, busy, done);
    check({tag, " Busy before last edge"}, 32'(busy), 32'd1);
    check({tag, " Done before last edge"}, 32'(done), 32'd0);
    tick();
    check_result(tag, v.d, v.ea, v.eb, v.ex);
  endtask

  initial begin
    logic x, busy, done;
    logic [31:0] a, b;

    vecs[0]  = '{0, 1'b1, 32'h00C5, 32'h0007, 32'h00FE, 32'h0063, 1'b1};
    vecs[1]  = '{0, 1'b0, 32'h0000, 32'h0002, 32'h0000, 32'h00C6, 1'b0};
    vecs[2]  = '{0, 1'b1, 32'h0080, 32'h0080, 32'h0040, 32'h0000, 1'b0};
    vecs[3]  = '{0, 1'b0, 32'h0000, 32'h0002, 32'h0000, 32'h0000, 1'b0};
    vecs[4]  = '{0, 1'b1, 32'h007F, 32'h007F, 32'h003F, 32'h0001, 1'b0};
    vecs[5]  = '{0, 1'b1, 32'h00FF, 32'h0001, 32'h00FF, 32'h00FF, 1'b1};
    vecs[6]  = '{1, 1'b1, 32'h00FF, 32'h00FF, 32'h00FE, 32'h0001, 1'b0};
    vecs[7]  = '{1, 1'b1, 32'h000D, 32'h000B, 32'h0000, 32'h008F, 1'b0};
    vecs[8]  = '{1, 1'b1, 32'h0080, 32'h0002, 32'h0001, 32'h0000, 1'b0};
    vecs[9]  = '{2, 1'b1, 32'h7FFF, 32'h8000, 32'hC000, 32'h8000, 1'b1};
    vecs[10] = '{2, 1'b1, 32'hFFFF, 32'hFFFF, 32'h0000, 32'h0001, 1'b0};

    for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b1, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      sample(d, x, a, b, busy, done);
      check($sformatf("reset d%0d A", d),    a, 32'd0);
      check($sformatf("reset d%0d B", d),    b, 32'd0);
      check($sformatf("reset d%0d X", d),    32'(x), 32'd0);
      check($sformatf("reset d%0d Busy", d), 32'(busy), 32'd0);
      check($sformatf("reset d%0d Done", d), 32'(done), 32'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Run held low in DONE must neither re-trigger nor disturb the product
    run_vec("hold", vecs[0]);
    repeat (10) tick();
    check_result("hold +10", 0, 32'h00FE, 32'h0063, 1'b1);

    // Run beats ClearA_LoadB in IDLE: 3 * 5 with B untouched by S
    release_run("prio", 0);
    load_b("prio", 0, 32'h03);
    drive(0, 1'b0, 1'b0, 32'h05);
    tick();
    drive(0, 1'b1, 1'b0, 32'h05);
    repeat (16) tick();
    check_result("prio", 0, 32'h0000, 32'h000F, 1'b0);

    // ClearA_LoadB pulsed mid-run is ignored
    release_run("intf", 0);
    load_b("intf", 0, 32'hC5);
    drive(0, 1'b1, 1'b0, 32'h07);
    tick();
    repeat (3) tick();
    drive(0, 1'b0, 1'b0, 32'h11);
    tick();
    drive(0, 1'b1, 1'b0, 32'h11);
    repeat (12) tick();
    check_result("intf", 0, 32'h00FE, 32'h0063, 1'b1);

    // Reset mid-run discards the partial product
    release_run("rstmid", 0);
    load_b("rstmid", 0, 32'hC5);
    drive(0, 1'b1, 1'b0, 32'h07);
    tick();
    repeat (5) tick();
    sample(0, x, a, b, busy, done);
    check("rstmid Busy before reset", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    sample(0, x, a, b, busy, done);
    check("rstmid A",    a, 32'd0);
    check("rstmid B",    b, 32'd0);
    check("rstmid X",    32'(x), 32'd0);
    check("rstmid Busy", 32'(busy), 32'd0);
    check("rstmid Done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'd0);
    tick();
    sample(0, x, a, b, busy, done);
    check("after reset Busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_seq_n.md
# mult_seq_n

Parametrised sequential add-shift multiplier, the successor to the 8-bit lab multiplier datapath. It multiplies a multiplicand M, latched from switches S, by the multiplier held in register B. The 2·WIDTH-bit product is left in A:B, with sign/carry bit X. It supports signed (two's-complement, subtract on final step) and unsigned modes and consecutive multiplication, where B keeps the low product half. It sits between the debounced push-button/switch inputs and the hex/LED display logic, which are external to this block.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- SIGNED, 1, 1 = two's-complement operands/product; 0 = unsigned
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low
- ClearA_LoadB  in  1  active-low; loads B from S and clears A and X
- Run  in  1  active-low; starts a multiplication
- S  in  WIDTH  switch operand (multiplicand, or B load value)
- X  out  1  sign extension (SIGNED=1) or carry (SIGNED=0) bit of A
- Aval  out  WIDTH  register A, upper product half
- Bval  out  WIDTH  register B, lower product half / multiplier
- Busy  out  1  high while a multiplication is in progress
- Done  out  1  high in DONE state

## Operation
- Registers: A, B, M (WIDTH each); X (1 bit); step counter (clog2(WIDTH)+1 bits); FSM state. Outputs are driven directly from registers.
- Reset low (any state): A, B, M, X, counter = 0; state = IDLE; Busy = Done = 0. Reset has priority over all other inputs.
- IDLE:
  - Run low: M←S, A←0, X←0, cnt←0, → ADD. Run has priority over ClearA_LoadB when both are low.
  - Else ClearA_LoadB low: B←S, A←0, X←0, stay in IDLE.
- ADD, bit step cnt:
  - If B[0]=0: A and X hold.
  - If B[0]=1 and SIGNED=1: {X,A} ← sext(A) ± sext(M), computed at WIDTH+1 bits. The operation is subtract when cnt = WIDTH−1, add otherwise.
  - If B[0]=1 and SIGNED=0: {X,A} ← {0,A} + {0,M}.
  - → SHIFT.
- SHIFT: {X,A,B} ← {X_new, X, A, B[WIDTH−1:1]}.
  - X_new = X when SIGNED=1 (arithmetic shift).
  - X_new = 0 when SIGNED=0.
  - cnt←cnt+1. → DONE if cnt = WIDTH−1, else → ADD.
- DONE: Done=1. A:B holds the product. → IDLE when Run is high; while Run stays low, remain in DONE (no re-trigger). ClearA_LoadB is ignored in DONE.
- Busy = state ∈ {ADD, SHIFT}. ClearA_LoadB and Run are ignored while Busy.
- Consecutive multiply: a new Run starts from the current B (the previous low half) with A cleared. The result is B_prev × S_new, reinterpreted under SIGNED.
- SIGNED=1 result: X = product sign bit. SIGNED=0 result: X = 0.

## Timing
- Start edge e0: Run sampled low in IDLE.
- Edges e1..e2W alternate ADD and SHIFT; the final SHIFT executes at e2W.
- After e2W: state = DONE, Done = 1, Aval/Bval/X final.
- Fixed latency: 2·WIDTH cycles, independent of operand values.
- Release: Run sampled high in DONE at edge k → IDLE after k, Done = 0. A new start needs Run high for at least one sampled cycle.
- ClearA_LoadB in IDLE: B = S and A = 0 visible one cycle after the sampling edge.
- Reset mid-operation: at the next edge all registers are zero and state is IDLE. The partial product is discarded.

## Test plan
- Reset: assert Reset low for 2 cycles in any state -> X=0, Aval=0, Bval=0, Busy=0, Done=0.
- Signed basic (WIDTH=8): ClearA_LoadB with S=0xC5, then Run with S=0x07 -> after exactly 16 cycles Aval=0xFE, Bval=0x63, X=1, Done=1. Holding Run low 10 more cycles causes no change.
- Signed corner: B=0x80, S=0x80 -> Aval=0x40, Bval=0x00, X=0. Then release Run, set S=0x02, Run again -> Aval=0x00, Bval=0x00, X=0 (product of 0x00×0x02).
- Consecutive: from A:B=0xFE63, release Run, set S=0x02, Run -> Aval=0x00, Bval=0xC6, X=0.
- Unsigned (SIGNED=0): B=0xFF, S=0xFF -> Aval=0xFE, Bval=0x01, X=0. WIDTH=16, SIGNED=1: B=0x7FFF, S=0x8000 -> Aval=0xC000, Bval=0x8000, X=1 after 32 cycles.
- Interference: ClearA_LoadB pulsed low at cycle 3 of a run -> ignored, result unchanged. Reset low at cycle 5 of a run -> all outputs 0 and Busy=0 one edge later.
